// File: rtl/demux_1x4_stream.sv
// demux_1x4_stream: 1-to-4 packet-aware stream demultiplexer.
// Each channel has a single output register. A packet stays locked to the
// channel chosen by its first beat until the beat carrying s_last.
// Optional feature macro: DEMUX_PKT_CNT_EN enables the per-channel 16-bit
// packet counters. When it is undefined, pkt_cnt is tied to zero.
module demux_1x4_stream #(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [W-1:0]   s_data,
    input  logic [1:0]     s_sel,
    input  logic           s_valid,
    input  logic           s_last,
    output logic           s_ready,
    output logic [4*W-1:0] m_data,
    output logic [3:0]     m_valid,
    output logic [3:0]     m_last,
    input  logic [3:0]     m_ready,
    output logic [63:0]    pkt_cnt
);

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 16;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ROUTE = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [1:0]            lock_ch_q, lock_ch_d;
    logic [NCH-1:0][W-1:0] data_q, data_d;
    logic [NCH-1:0]        valid_q, valid_d;
    logic [NCH-1:0]        last_q, last_d;
    logic [1:0]            tgt_ch;
    logic                  accept;

    // Target channel selection and upstream handshake.
    // The target register must be empty or draining this cycle.
    always_comb begin
        tgt_ch  = (state_q == ROUTE) ? lock_ch_q : s_sel;
        s_ready = reset_n & (~valid_q[tgt_ch] | m_ready[tgt_ch]);
        accept  = s_valid & s_ready;
    end

    // Per-channel output registers: the channel loads on an accepted beat
    // and clears its valid bit when drained.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        for (int k = 0; k < NCH; k++) begin
            if (accept && (tgt_ch == 2'(k))) begin
                data_d[k]  = s_data;
                last_d[k]  = s_last;
                valid_d[k] = 1'b1;
            end else if (valid_q[k] && m_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Packet lock FSM. A multi-beat packet locks onto its first beat's channel.
    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        case (state_q)
            IDLE: begin
                if (accept && !s_last) begin
                    state_d   = ROUTE;
                    lock_ch_d = s_sel;
                end
            end
            ROUTE: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and channel registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lock_ch_q <= 2'd0;
            data_q    <= '0;
            valid_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
        end
    end

    assign m_data  = data_q;
    assign m_valid = valid_q;
    assign m_last  = last_q;

`ifdef DEMUX_PKT_CNT_EN
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;

    // Count each packet once, on its last beat; each counter wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && s_last) begin
            cnt_d[tgt_ch] = cnt_q[tgt_ch] + CW'(1);
        end
    end

    // Packet counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench for demux_1x4_stream. Scoreboard queues per channel hold
// beats expected on each output; they are filled on acceptance and checked on drain.
module tb_demux_1x4_stream;

    localparam int unsigned W = 8;

    typedef logic [W:0] beat_t;

    logic           clk;
    logic           reset_n;
    logic [W-1:0]   s_data;
    logic [1:0]     s_sel;
    logic           s_valid;
    logic           s_last;
    logic           s_ready;
    logic [4*W-1:0] m_data;
    logic [3:0]     m_valid;
    logic [3:0]     m_last;
    logic [3:0]     m_ready;
    logic [63:0]    pkt_cnt;

    int          n_cmp;
    int          n_err;
    int          cur_ch;
    logic        accepted;
    beat_t       exp_q [4][$];
    logic [15:0] exp_cnt [4];

    demux_1x4_stream #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_ready (m_ready),
        .pkt_cnt (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_pkt();
`ifdef DEMUX_PKT_CNT_EN
        return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
`else
        return 64'd0;
`endif
    endfunction

    // One clock: sample handshakes at negedge, update the scoreboard, and
    // return 1 time unit after the rising edge.
    task automatic step();
        beat_t got;
        @(negedge clk);
        accepted = 1'b0;
        if (s_valid && s_ready) begin
            accepted = 1'b1;
            exp_q[cur_ch].push_back({s_last, s_data});
            if (s_last) exp_cnt[cur_ch] = exp_cnt[cur_ch] + 16'd1;
        end
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && m_ready[k]) begin
                n_cmp++;
                if (exp_q[k].size() == 0) begin
                    n_err++;
                    $display("FAIL drain_ch%0d: got last/data=%0b/%h, required no beat",
                             k, m_last[k], m_data[k*W +: W]);
                end else begin
                    got = exp_q[k].pop_front();
                    if ({m_last[k], m_data[k*W +: W]} !== got) begin
                        n_err++;
                        $display("FAIL drain_ch%0d: got last/data=%0b/%h, required %0b/%h",
                                 k, m_last[k], m_data[k*W +: W], got[W], got[W-1:0]);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] sel,
                        input logic last, input int ch);
        s_data  = d;
        s_sel   = sel;
        s_last  = last;
        s_valid = 1'b1;
        cur_ch  = ch;
        for (int i = 0; i < 20; i++) begin
            step();
            if (accepted) break;
        end
        s_valid = 1'b0;
        n_cmp++;
        if (!accepted) begin
            n_err++;
            $display("FAIL send_timeout: beat %h not accepted, accepted=%0b required 1", d, accepted);
        end
    endtask

    task automatic drain();
        int n;
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            n = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
            if (n == 0 && m_valid == 4'b0) break;
            step();
        end
        n = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
        n_cmp++;
        if (n != 0 || m_valid !== 4'b0) begin
            n_err++;
            $display("FAIL drain_empty: pending=%0d m_valid=%b, required 0/0000", n, m_valid);
        end
        n_cmp++;
        if (pkt_cnt !== exp_pkt()) begin
            n_err++;
            $display("FAIL pkt_cnt: got %h required %h", pkt_cnt, exp_pkt());
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            exp_q[k].delete();
            exp_cnt[k] = 16'd0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_sel   = 2'd0;
        s_last  = 1'b0;
        m_ready = 4'hF;
        cur_ch  = 0;
        clear_model();
        #2;
        n_cmp++;
        if (s_ready !== 1'b0 || m_valid !== 4'b0 || m_last !== 4'b0 ||
            m_data !== '0 || pkt_cnt !== 64'd0) begin
            n_err++;
            $display("FAIL reset_state: s_ready=%b m_valid=%b m_last=%b m_data=%h pkt_cnt=%h, required all 0",
                     s_ready, m_valid, m_last, m_data, pkt_cnt);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (s_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b required 1", s_ready);
        end
    endtask

    task automatic test_single();
        m_ready = 4'hF;
        send(8'hA1, 2'd0, 1'b1, 0);
        n_cmp++;
        if (m_valid !== 4'b0001 || m_data[7:0] !== 8'hA1 || m_last[0] !== 1'b1) begin
            n_err++;
            $display("FAIL single_ch0: m_valid=%b data=%h last=%b, required 0001/a1/1",
                     m_valid, m_data[7:0], m_last[0]);
        end
        send(8'hB2, 2'd3, 1'b1, 3);
        n_cmp++;
        if (m_valid !== 4'b1000 || m_data[31:24] !== 8'hB2 || m_last[3] !== 1'b1) begin
            n_err++;
            $display("FAIL single_ch3: m_valid=%b data=%h last=%b, required 1000/b2/1",
                     m_valid, m_data[31:24], m_last[3]);
        end
        step();
        n_cmp++;
        if (m_valid !== 4'b0000) begin
            n_err++;
            $display("FAIL single_pulse: m_valid=%b required 0000", m_valid);
        end
        drain();
    endtask

    task automatic test_route();
        m_ready = 4'hF;
        send(8'h10, 2'd2, 1'b0, 2);
        send(8'h11, 2'd1, 1'b0, 2);
        n_cmp++;
        if (m_valid[1] !== 1'b0 || m_data[23:16] !== 8'h11) begin
            n_err++;
            $display("FAIL route_lock: m_valid[1]=%b ch2 data=%h, required 0/11", m_valid[1], m_data[23:16]);
        end
        send(8'h12, 2'd1, 1'b1, 2);
        n_cmp++;
        if (m_valid !== 4'b0100 || m_data[23:16] !== 8'h12 || m_last[2] !== 1'b1) begin
            n_err++;
            $display("FAIL route_last: m_valid=%b data=%h last=%b, required 0100/12/1",
                     m_valid, m_data[23:16], m_last[2]);
        end
        send(8'h13, 2'd1, 1'b1, 1);
        n_cmp++;
        if (m_valid !== 4'b0010 || m_data[15:8] !== 8'h13) begin
            n_err++;
            $display("FAIL route_idle: m_valid=%b ch1 data=%h, required 0010/13", m_valid, m_data[15:8]);
        end
        drain();
    endtask

    task automatic test_stall();
        logic took;
        m_ready = 4'b1101;
        send(8'h21, 2'd1, 1'b1, 1);
        s_data  = 8'h22;
        s_sel   = 2'd1;
        s_last  = 1'b1;
        s_valid = 1'b1;
        cur_ch  = 1;
        took    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (s_ready !== 1'b0 || m_valid[1] !== 1'b1 || m_data[15:8] !== 8'h21) begin
                n_err++;
                $display("FAIL stall_hold: s_ready=%b m_valid[1]=%b data=%h, required 0/1/21",
                         s_ready, m_valid[1], m_data[15:8]);
            end
            step();
            took = took | accepted;
        end
        m_ready = 4'hF;
        step();
        took = took | ~accepted;
        s_valid = 1'b0;
        n_cmp++;
        if (took !== 1'b0 || m_valid[1] !== 1'b1 || m_data[15:8] !== 8'h22) begin
            n_err++;
            $display("FAIL stall_release: bad_accept=%b m_valid[1]=%b data=%h, required 0/1/22",
                     took, m_valid[1], m_data[15:8]);
        end
        drain();
    endtask

    task automatic test_isolation();
        m_ready = 4'b1110;
        send(8'h30, 2'd0, 1'b1, 0);
        for (int j = 0; j < 3; j++) begin
            send(8'h31 + 8'(j), 2'd3, 1'b1, 3);
            n_cmp++;
            if (m_valid[0] !== 1'b1 || m_data[7:0] !== 8'h30 || m_valid[3] !== 1'b1) begin
                n_err++;
                $display("FAIL isolation: m_valid=%b ch0 data=%h, required 1xx1/30", m_valid, m_data[7:0]);
            end
        end
        step();
        n_cmp++;
        if (m_valid !== 4'b0001) begin
            n_err++;
            $display("FAIL isolation_drain: m_valid=%b required 0001", m_valid);
        end
        m_ready = 4'hF;
        drain();
    endtask

    task automatic test_reset_mid();
        m_ready = 4'b1011;
        send(8'h40, 2'd2, 1'b0, 2);
        n_cmp++;
        if (m_valid !== 4'b0100) begin
            n_err++;
            $display("FAIL mid_buffer: m_valid=%b required 0100", m_valid);
        end
        s_sel   = 2'd0;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (m_valid !== 4'b0 || m_data !== '0 || m_last !== 4'b0 ||
            s_ready !== 1'b0 || pkt_cnt !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset: m_valid=%b m_data=%h m_last=%b s_ready=%b pkt_cnt=%h, required all 0",
                     m_valid, m_data, m_last, s_ready, pkt_cnt);
        end
        clear_model();
        step();
        step();
        reset_n = 1'b1;
        m_ready = 4'hF;
        send(8'h41, 2'd0, 1'b1, 0);
        n_cmp++;
        if (m_valid !== 4'b0001 || m_data[7:0] !== 8'h41) begin
            n_err++;
            $display("FAIL mid_restart: m_valid=%b ch0 data=%h, required 0001/41", m_valid, m_data[7:0]);
        end
        drain();
    endtask

    task automatic test_pkt_cnt();
        m_ready = 4'hF;
`ifdef DEMUX_PKT_CNT_EN
        reset_n = 1'b0;
        #1;
        clear_model();
        reset_n = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            send(8'(i), 2'd1, 1'b1, 1);
        end
        drain();
        n_cmp++;
        if (pkt_cnt[31:16] !== 16'd1 || pkt_cnt[15:0] !== 16'd0 || pkt_cnt[63:32] !== 32'd0) begin
            n_err++;
            $display("FAIL pkt_cnt_wrap: got %h required 0000000000010000", pkt_cnt);
        end
`else
        for (int i = 0; i < 4; i++) begin
            send(8'h50 + 8'(i), 2'(i), 1'b1, i);
            n_cmp++;
            if (pkt_cnt !== 64'd0) begin
                n_err++;
                $display("FAIL pkt_cnt_off: got %h required 0", pkt_cnt);
            end
        end
        drain();
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_route();
        test_stall();
        test_isolation();
        test_reset_mid();
        test_pkt_cnt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1x4_stream.md
DEMUX_1X4_STREAM -- requirements
Module: demux_1x4_stream

Interface
REQ-001 SHALL have parameter W, default 8, the data width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port s_data, input, W bits: upstream beat data.
REQ-005 SHALL have port s_sel, input, 2 bits: destination channel, 0..3.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream beat valid.
REQ-007 SHALL have port s_last, input, 1 bit: marks the final beat of a packet.
REQ-008 SHALL have port s_ready, output, 1 bit: upstream beat accepted when s_valid and s_ready are both 1.
REQ-009 SHALL have port m_data, output, 4*W bits: channel k data in bits [k*W +: W].
REQ-010 SHALL have port m_valid, output, 4 bits: per-channel valid.
REQ-011 SHALL have port m_last, output, 4 bits: per-channel last.
REQ-012 SHALL have port m_ready, input, 4 bits: per-channel downstream ready.
REQ-013 SHALL have port pkt_cnt, output, 64 bits: per-channel packet count, channel k in bits [k*16 +: 16].

Function
REQ-014 SHALL hold one output register per channel (data, last, valid); a beat is drained from channel k when m_valid[k] and m_ready[k] are both 1.
REQ-015 SHALL implement FSM states IDLE (no packet in progress) and ROUTE (packet locked to channel lock_ch).
REQ-016 In IDLE, the target channel SHALL be s_sel; in ROUTE, it SHALL be lock_ch, and s_sel SHALL be ignored.
REQ-017 s_ready SHALL be 1 when the target channel register is empty or is being drained in the same cycle, and 0 otherwise; s_ready SHALL be combinational and independent of s_valid.
REQ-018 An accepted beat SHALL appear on the target channel's outputs in the next cycle: 1-cycle latency, m_valid[k] set, data and last copied.
REQ-019 A simultaneous drain and accept on the same channel SHALL load the new beat with m_valid held at 1, giving full throughput of 1 beat per cycle.
REQ-020 An accepted beat in IDLE with s_last=0 SHALL latch lock_ch=s_sel and move the FSM to ROUTE.
REQ-021 An accepted beat in IDLE with s_last=1 is a single-beat packet; the FSM SHALL stay in IDLE.
REQ-022 An accepted beat in ROUTE with s_last=1 SHALL return the FSM to IDLE.
REQ-023 A stalled channel SHALL NOT block drains on other channels; only upstream acceptance stalls.
REQ-024 Untargeted channel registers SHALL be unaffected by upstream activity.
REQ-025 m_data[k] SHALL hold its value while m_valid[k]=1 and m_ready[k]=0.

Reset
REQ-026 While reset_n=0, the block SHALL set the FSM to IDLE, lock_ch to 0, m_valid to 0, m_last to 0, m_data to 0 and pkt_cnt to 0, independently of clk.
REQ-027 Assertion of reset_n mid-packet SHALL discard the lock and all buffered beats; the first beat accepted after release SHALL be treated as a packet start.
REQ-028 While reset_n=0, s_ready SHALL be 0.

Configuration
REQ-029 With macro DEMUX_PKT_CNT_EN defined, pkt_cnt channel k SHALL increment by 1, wrapping from 16'hFFFF to 0, on each accepted beat with s_last=1 routed to channel k.
REQ-030 Without DEMUX_PKT_CNT_EN, pkt_cnt SHALL be constant 0 and no counter registers SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL cover: single-beat packets 0xA1/sel0, 0xB2/sel3 with all m_ready=1 -> m_data ch0=0xA1 and ch3=0xB2, each m_valid pulse 1 cycle after acceptance, m_last=1.
REQ-032 Bench SHALL cover: a 3-beat packet 0x10,0x11,0x12 with sel=2 on beat 1 and sel toggled to 1 on beats 2-3 -> all beats on ch2, ch1 untouched, FSM back in IDLE after 0x12.
REQ-033 Bench SHALL cover: m_ready[1]=0 with 2 beats sent to ch1 -> first beat held stable, s_ready=0 on the second; raising m_ready[1] drains 0x?? in order with no loss or duplication.
REQ-034 Bench SHALL cover: m_ready[0]=0 stalling ch0 while single-beat packets are sent to ch3 -> ch3 beats still flow and drain.
REQ-035 Bench SHALL cover: reset_n pulsed low mid-packet (after beat 1 of 3 to ch2) -> all m_valid=0 immediately, and the next beat routes by its own s_sel.
REQ-036 Bench SHALL cover, with DEMUX_PKT_CNT_EN defined: 65537 single-beat packets to ch1 -> pkt_cnt ch1=1; without the macro, pkt_cnt=0 throughout.
